// File: rtl/line_feeder_if.sv
//------------------------------------------------------------------------------
// line_feeder_if - image-memory read port plus pixel-column stream.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface line_feeder_if #(
  parameter int BIT_DEPTH = 8,
  parameter int ADDR_W    = 10
);
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [BIT_DEPTH-1:0] mem_rd_data;
  logic                 shift_buffer;
  logic [BIT_DEPTH-1:0] pix_l1;
  logic [BIT_DEPTH-1:0] pix_l2;
  logic [BIT_DEPTH-1:0] pix_l3;
  logic                 ready;
  logic                 row_end;

  modport master (
    output mem_rd_en, mem_addr, pix_l1, pix_l2, pix_l3, ready, row_end,
    input  mem_rd_data, shift_buffer
  );

  modport slave (
    input  mem_rd_en, mem_addr, pix_l1, pix_l2, pix_l3, ready, row_end,
    output mem_rd_data, shift_buffer
  );
endinterface

`default_nettype wire

// File: rtl/line_feeder.sv
//------------------------------------------------------------------------------
// line_feeder - three-row line buffer feeding pixel columns to a conv engine.
// Optional macro LINE_FEEDER_ZERO_PAD_EN adds a zero column on each row side. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module line_feeder #(
  parameter int BIT_DEPTH = 8,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int ADDR_W    = 10
) (
  input  wire                 clk,
  input  wire                 rst,
  input  wire                 start,
  input  wire  [1:0]          stride,
  output logic                done,
  line_feeder_if.master       bus
);

`ifdef LINE_FEEDER_ZERO_PAD_EN
  localparam int c_ncols = IMG_W + 2;
`else
  localparam int c_ncols = IMG_W;
`endif
  localparam int CW = $clog2(c_ncols);
  localparam int IW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 8);
  localparam logic [CW-1:0] c_last_col = CW'(c_ncols - 1);
  localparam logic [IW-1:0] c_last_rd  = IW'(IMG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_SERVE  = 3'd2,
    S_REFILL = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  logic [1:0]           r_stride;
  logic [RW-1:0]        r_top;
  logic [CW-1:0]        r_col;
  logic [1:0]           r_rot;
  logic [RW-1:0]        r_iss_row;
  logic [IW-1:0]        r_iss_col;
  logic [1:0]           r_iss_slot;
  logic [1:0]           r_iss_left;
  logic                 r_rd_en;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_wr_en;
  logic [1:0]           r_wr_slot;
  logic [IW-1:0]        r_wr_col;
  logic                 r_ready;
  logic                 r_row_end;
  logic                 r_done;
  logic [BIT_DEPTH-1:0] r_hold1, r_hold2, r_hold3;
  logic [BIT_DEPTH-1:0] r_line [3][IMG_W];

  // Slot index arithmetic modulo 3 (base < 3, off <= 2).
  function automatic logic [1:0] f_slot(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    f_slot = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] f_addr(input logic [RW-1:0] row, input logic [IW-1:0] col);
    f_addr = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
  endfunction

  logic                 w_iss_wrap;
  logic [IW-1:0]        w_nxt_col;
  logic [RW-1:0]        w_nxt_row;
  logic [RW-1:0]        w_top_nxt;
  logic [RW-1:0]        w_ref_row;
  logic                 w_more;
  logic                 w_last;
  logic [IW-1:0]        w_bcol;
  logic [1:0]           w_s1, w_s2;
  logic [BIT_DEPTH-1:0] w_cur1, w_cur2, w_cur3;

  assign w_iss_wrap = (r_iss_col == c_last_rd);
  assign w_nxt_col  = w_iss_wrap ? '0 : r_iss_col + IW'(1);
  assign w_nxt_row  = w_iss_wrap ? r_iss_row + RW'(1) : r_iss_row;
  assign w_top_nxt  = r_top + RW'(r_stride);
  assign w_ref_row  = r_top + RW'(3);
  assign w_more     = (w_top_nxt + RW'(2)) <= RW'(IMG_H - 1);
  assign w_last     = (r_col == c_last_col);
  assign w_s1       = f_slot(r_rot, 2'd1);
  assign w_s2       = f_slot(r_rot, 2'd2);

`ifdef LINE_FEEDER_ZERO_PAD_EN
  logic w_pad;
  assign w_pad  = (r_col == '0) || w_last;
  assign w_bcol = IW'(r_col - CW'(1));
`else
  assign w_bcol = IW'(r_col);
`endif

  always_comb begin
    w_cur1 = r_line[r_rot][w_bcol];
    w_cur2 = r_line[w_s1][w_bcol];
    w_cur3 = r_line[w_s2][w_bcol];
`ifdef LINE_FEEDER_ZERO_PAD_EN
    if (w_pad) begin
      w_cur1 = '0;
      w_cur2 = '0;
      w_cur3 = '0;
    end
`endif
  end

  // Read data lands one cycle after its strobe; the write side just trails the issue side.
  always_ff @(posedge clk) begin
    if (r_wr_en) r_line[r_wr_slot][r_wr_col] <= bus.mem_rd_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_stride   <= 2'd1;
      r_top      <= '0;
      r_col      <= '0;
      r_rot      <= '0;
      r_iss_row  <= '0;
      r_iss_col  <= '0;
      r_iss_slot <= '0;
      r_iss_left <= '0;
      r_rd_en    <= 1'b0;
      r_addr     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_slot  <= '0;
      r_wr_col   <= '0;
      r_ready    <= 1'b0;
      r_row_end  <= 1'b0;
      r_done     <= 1'b0;
      r_hold1    <= '0;
      r_hold2    <= '0;
      r_hold3    <= '0;
    end else begin
      r_row_end <= 1'b0;
      r_done    <= 1'b0;
      r_wr_en   <= r_rd_en;
      r_wr_slot <= r_iss_slot;
      r_wr_col  <= r_iss_col;
      if (r_state == S_SERVE) begin
        r_hold1 <= w_cur1;
        r_hold2 <= w_cur2;
        r_hold3 <= w_cur3;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_stride   <= (stride == 2'd2) ? 2'd2 : 2'd1;
            r_top      <= '0;
            r_col      <= '0;
            r_rot      <= '0;
            r_iss_row  <= '0;
            r_iss_col  <= '0;
            r_iss_slot <= '0;
            r_iss_left <= 2'd3;
            r_addr     <= '0;
            r_rd_en    <= 1'b1;
            r_state    <= S_FILL;
          end
        end

        S_FILL, S_REFILL: begin
          if (r_rd_en) begin
            r_iss_col <= w_nxt_col;
            r_iss_row <= w_nxt_row;
            r_addr    <= f_addr(w_nxt_row, w_nxt_col);
            if (w_iss_wrap) begin
              r_iss_slot <= f_slot(r_iss_slot, 2'd1);
              r_iss_left <= r_iss_left - 2'd1;
              if (r_iss_left == 2'd1) r_rd_en <= 1'b0;
            end
          end else begin
            // Drain cycle: the final write completes on this edge.
            r_state <= S_SERVE;
            r_ready <= 1'b1;
          end
        end

        S_SERVE: begin
          if (bus.shift_buffer) begin
            if (w_last) begin
              r_col     <= '0;
              r_top     <= w_top_nxt;
              r_row_end <= 1'b1;
              r_ready   <= 1'b0;
              if (w_more) begin
                // New rows overwrite the oldest slots, which start at the current rotation.
                r_state    <= S_REFILL;
                r_rot      <= f_slot(r_rot, r_stride);
                r_iss_row  <= w_ref_row;
                r_iss_col  <= '0;
                r_iss_slot <= r_rot;
                r_iss_left <= r_stride;
                r_addr     <= f_addr(w_ref_row, '0);
                r_rd_en    <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end

        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en = r_rd_en;
  assign bus.mem_addr  = r_addr;
  assign bus.ready     = r_ready;
  assign bus.row_end   = r_row_end;
  assign done          = r_done;
  assign bus.pix_l1    = (r_state == S_SERVE) ? w_cur1 : r_hold1;
  assign bus.pix_l2    = (r_state == S_SERVE) ? w_cur2 : r_hold2;
  assign bus.pix_l3    = (r_state == S_SERVE) ? w_cur3 : r_hold3;

endmodule

`default_nettype wire

// File: tb/tb_line_feeder.sv
//------------------------------------------------------------------------------
// tb_line_feeder - scoreboard bench for line_feeder against a pixel-formula model. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_feeder;
  localparam int BIT_DEPTH = 8;
  localparam int IMG_W     = 28;
  localparam int IMG_H     = 28;
  localparam int ADDR_W    = 10;
`ifdef LINE_FEEDER_ZERO_PAD_EN
  localparam int COLS = IMG_W + 2;
  localparam int PO   = 1;
`else
  localparam int COLS = IMG_W;
  localparam int PO   = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] stride = 2'd1;
  logic       done;

  line_feeder_if #(.BIT_DEPTH(BIT_DEPTH), .ADDR_W(ADDR_W)) bus ();

  line_feeder #(
    .BIT_DEPTH(BIT_DEPTH),
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stride(stride),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

  typedef struct packed {
    logic [7:0] p1;
    logic [7:0] p2;
    logic [7:0] p3;
    logic       last;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0, exp_re = 0, hold_chk = 0, first_rd = 0, refill_pend = 0;
  int          re_cnt, done_cnt, rd_cnt, rd_since_re, last_refill_rd, acc_cnt;
  logic [23:0] obs [0:4095];
  logic [23:0] hold_pix;

  function automatic logic [7:0] pixel(input int r, input int c);
    return 8'((r * 28 + c) % 256);
  endfunction

  // Monitor: pops one expected column per accepted shift and tracks pulses/reads.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (bus.row_end !== exp_re) begin
        errors++;
        $display("FAIL row_end timing: got %b want %b (accepted=%0d)", bus.row_end, exp_re, acc_cnt);
      end
      exp_re = 1'b0;
      if (bus.row_end === 1'b1) begin re_cnt++; rd_since_re = 0; refill_pend = 1; end
      if (done === 1'b1) done_cnt++;
      if (bus.mem_rd_en === 1'b1) begin
        rd_cnt++;
        rd_since_re++;
        if (first_rd) begin
          first_rd = 0;
          checks++;
          if (bus.mem_addr !== '0) begin
            errors++;
            $display("FAIL first_addr: got %0d want 0", bus.mem_addr);
          end
        end
      end
      if (bus.ready === 1'b1 && refill_pend) begin last_refill_rd = rd_since_re; refill_pend = 0; end
      if (bus.ready === 1'b1 && bus.shift_buffer === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL extra_shift: got column %0d want none", acc_cnt);
        end else begin
          mon_e = sb_q.pop_front();
          if ({bus.pix_l1, bus.pix_l2, bus.pix_l3} !== {mon_e.p1, mon_e.p2, mon_e.p3}) begin
            errors++;
            $display("FAIL pix col#%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", acc_cnt,
                     bus.pix_l1, bus.pix_l2, bus.pix_l3, mon_e.p1, mon_e.p2, mon_e.p3);
          end
          exp_re = mon_e.last;
          if (acc_cnt < 4096) obs[acc_cnt] = {bus.pix_l1, bus.pix_l2, bus.pix_l3};
          acc_cnt++;
          hold_pix = {mon_e.p1, mon_e.p2, mon_e.p3};
          hold_chk = 1;
        end
      end else if (bus.ready !== 1'b1 && hold_chk) begin
        checks++;
        if ({bus.pix_l1, bus.pix_l2, bus.pix_l3} !== hold_pix) begin
          errors++;
          $display("FAIL pix_hold: got %h want %h", {bus.pix_l1, bus.pix_l2, bus.pix_l3}, hold_pix);
        end
      end
    end
  end

  task automatic run_frame(input int strd, input bit disturb);
    int   ntrip, fill_cyc, cyc, col;
    bit   poked;
    exp_t e;
    ntrip = (IMG_H - 3) / strd + 1;
    sb_q.delete();
    for (int t = 0; t < ntrip; t++) begin
      for (int c = 0; c < COLS; c++) begin
        col = c - PO;
        if (col < 0 || col >= IMG_W) begin
          e.p1 = 8'd0; e.p2 = 8'd0; e.p3 = 8'd0;
        end else begin
          e.p1 = pixel(t * strd, col);
          e.p2 = pixel(t * strd + 1, col);
          e.p3 = pixel(t * strd + 2, col);
        end
        e.last = (c == COLS - 1);
        sb_q.push_back(e);
      end
    end
    re_cnt = 0; done_cnt = 0; rd_cnt = 0; rd_since_re = 0; last_refill_rd = -1; acc_cnt = 0;
    refill_pend = 0; first_rd = 1; exp_re = 0;
    @(posedge clk); #1;
    mon_en = 1;
    stride = 2'(strd);
    start = 1'b1;
    bus.shift_buffer = disturb ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fill_cyc = 0;
    do begin
      @(negedge clk);
      if (bus.ready !== 1'b1) fill_cyc++;
    end while (bus.ready !== 1'b1 && fill_cyc < 200);
    checks++;
    if (fill_cyc != 3 * IMG_W + 1) begin
      errors++;
      $display("FAIL fill_cycles: got %0d want %0d", fill_cyc, 3 * IMG_W + 1);
    end
    cyc = 0;
    poked = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(posedge clk); #1;
      if (disturb) begin
        bus.shift_buffer = 1'($urandom_range(0, 1));
        start = (!poked && bus.ready === 1'b1 && acc_cnt > 3);
        if (start) poked = 1;
      end
      cyc++;
    end
    start = 1'b0;
    bus.shift_buffer = 1'b0;
    repeat (4) @(negedge clk);
    mon_en = 0;
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d want 1", done_cnt);
    end
    checks++;
    if (re_cnt != ntrip) begin
      errors++;
      $display("FAIL row_end_count: got %0d want %0d", re_cnt, ntrip);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL columns_left: got %0d want 0", sb_q.size());
    end
    checks++;
    if (rd_cnt != 3 * IMG_W + (ntrip - 1) * strd * IMG_W) begin
      errors++;
      $display("FAIL total_reads: got %0d want %0d", rd_cnt, 3 * IMG_W + (ntrip - 1) * strd * IMG_W);
    end
    checks++;
    if (last_refill_rd != strd * IMG_W) begin
      errors++;
      $display("FAIL refill_reads: got %0d want %0d", last_refill_rd, strd * IMG_W);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start = 1'b0;
    bus.shift_buffer = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.mem_rd_en, bus.ready, bus.row_end, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {bus.mem_rd_en, bus.ready, bus.row_end, done});
    end
    checks++;
    if ({bus.pix_l1, bus.pix_l2, bus.pix_l3} !== 24'h0) begin
      errors++;
      $display("FAIL reset_pix: got %h want 000000", {bus.pix_l1, bus.pix_l2, bus.pix_l3});
    end
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_fill;
    int n, cyc;
    @(posedge clk); #1;
    stride = 2'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 100) begin
      @(negedge clk);
      if (bus.mem_rd_en === 1'b1) n++;
      cyc++;
    end
    checks++;
    if (n != 10) begin errors++; $display("FAIL mid_fill_reads: got %0d want 10", n); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_rd_en, bus.ready} !== 2'b00) begin
      errors++;
      $display("FAIL mid_fill_reset: got rd_en/ready %b want 00", {bus.mem_rd_en, bus.ready});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_rd_en, bus.ready, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 000", {bus.mem_rd_en, bus.ready, done});
    end
  endtask

  task automatic test_stride1;
    run_frame(1, 1'b0);
    checks++;
    if (obs[PO] !== {8'd0, 8'd28, 8'd56}) begin
      errors++; $display("FAIL s1_first: got %h want 001c38", obs[PO]);
    end
    checks++;
    if (obs[PO + 5] !== {8'd5, 8'd33, 8'd61}) begin
      errors++; $display("FAIL s1_col5: got %h want 05213d", obs[PO + 5]);
    end
    checks++;
    if (obs[COLS + PO] !== {8'd28, 8'd56, 8'd84}) begin
      errors++; $display("FAIL s1_second: got %h want 1c3854", obs[COLS + PO]);
    end
`ifdef LINE_FEEDER_ZERO_PAD_EN
    checks++;
    if (obs[0] !== 24'h0) begin errors++; $display("FAIL pad_left: got %h want 000000", obs[0]); end
    checks++;
    if (obs[COLS - 1] !== 24'h0) begin errors++; $display("FAIL pad_right: got %h want 000000", obs[COLS - 1]); end
`endif
  endtask

  task automatic test_stride2;
    run_frame(2, 1'b0);
    checks++;
    if (obs[COLS + PO] !== {8'd56, 8'd84, 8'd112}) begin
      errors++; $display("FAIL s2_second: got %h want 385470", obs[COLS + PO]);
    end
  endtask

  task automatic test_ignored_inputs;
    run_frame(1, 1'b1);
    checks++;
    if (obs[COLS + PO] !== {8'd28, 8'd56, 8'd84}) begin
      errors++; $display("FAIL ign_second: got %h want 1c3854", obs[COLS + PO]);
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'hEE;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        mem[r * IMG_W + c] = pixel(r, c);
    bus.shift_buffer = 1'b0;
    test_reset();
    test_reset_mid_fill();
    test_stride1();
    test_stride2();
    test_ignored_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/line_feeder.md
Name: line_feeder

Overview:
- Source end of the line-buffer interface that the convolution engine consumes.
- Fetches image rows from a single-port image memory (1-cycle read latency) into three internal row buffers.
- Answers `shift_buffer` requests by presenting one column of three vertically adjacent pixels on `pix_l1/l2/l3`.
- At end of row it refills 1 or 2 rows, by vertical stride, and rotates the row mapping. Asserts `done` after the last row triplet is consumed.

Parameters:
- `BIT_DEPTH`, 8, pixel width.
- `IMG_W`, 28, image width in pixels.
- `IMG_H`, 28, image height in rows.
- `ADDR_W`, 10, image memory address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.

Ports:
- `clk`  input  1  clock, rising edge.
- `rst`  input  1  asynchronous active-low reset.
- `start`  input  1  begin a frame; sampled only in IDLE.
- `stride`  input  2  vertical row stride, 1 or 2; latched at start.
- `shift_buffer`  input  1  consumer requests next column.
- `mem_rd_en`  output  1  image memory read strobe.
- `mem_addr`  output  ADDR_W  image memory address = row*IMG_W + col.
- `mem_rd_data`  input  BIT_DEPTH  read data, valid one cycle after `mem_rd_en`.
- `pix_l1`  output  BIT_DEPTH  pixel at (top row, col).
- `pix_l2`  output  BIT_DEPTH  pixel at (top+1, col).
- `pix_l3`  output  BIT_DEPTH  pixel at (top+2, col).
- `ready`  output  1  buffers valid; `shift_buffer` is accepted.
- `row_end`  output  1  one-cycle pulse when the last column of a triplet is accepted.
- `done`  output  1  one-cycle pulse: frame complete.

Behaviour:
- Reset (`rst`=0, async):
  - state=IDLE; all outputs 0; `col`=0, `top`=0, rotation pointer=0.
  - Row buffer contents are don't-care and need not be cleared.
  - Reset mid-fill or mid-serve abandons the frame immediately.
- States: IDLE, FILL, SERVE, REFILL, DONE.
- IDLE:
  - On `start`: latch stride (0 or 3 treated as 1), `top`=0, `col`=0, go to FILL.
- FILL:
  - Issue 3*IMG_W consecutive reads, rows 0..2, one per cycle; `mem_rd_en`=1 for exactly those cycles.
  - Write each `mem_rd_data` the cycle after its read.
  - Enter SERVE the cycle after the last data is written (3*IMG_W+1 cycles after leaving IDLE).
- SERVE:
  - `ready`=1.
  - `pix_l*` are combinational from the buffers at current `col` through the rotation mapping; valid in the same cycle as `shift_buffer`.
  - `shift_buffer`=1 advances `col` on the clock edge.
  - `shift_buffer` at `col`=IMG_W-1:
    - pulse `row_end`; `col`<=0; `top`<=`top`+stride.
    - If `top`+stride+2 ≤ IMG_H-1, go to REFILL; else go to DONE.
- REFILL:
  - `ready`=0; `pix_l*` hold their last value.
  - Read `stride` new rows (`top`+3-stride .. `top`+2) into the oldest buffer slot(s): IMG_W*stride reads plus one drain cycle.
  - Rotation pointer advances by `stride` mod 3.
  - Then return to SERVE.
- DONE: pulse `done` for 1 cycle; `ready`=0; return to IDLE.
- `shift_buffer` outside SERVE is ignored: no `col` change, no error.
- `start` outside IDLE is ignored.
- Address arithmetic:
  - `mem_addr` is computed as `row`*IMG_W+`col` in ADDR_W bits.
  - A row index ≥ IMG_H is never issued.
- Outputs registered except `pix_l*`.

Optional Feature:
- Macro: `LINE_FEEDER_ZERO_PAD_EN`.
- When defined:
  - Each row is presented as IMG_W+2 columns; the first and last accepted shifts return 0 on all `pix_l*`.
  - `row_end` fires at padded column IMG_W+1.
  - Memory reads are unchanged.
- When undefined: exactly IMG_W columns per triplet, no padding logic.

Test Plan:
- Memory preloaded with pixel(r,c) = (r*28+c) mod 256.
- Test 1: reset low mid-FILL (after 10 reads) → next cycle `mem_rd_en`=0, `ready`=0, state IDLE; following start refills from address 0.
- Test 2: start, stride=1; hold `shift_buffer`=1 in SERVE → first triplet (0,28,56), col 5 → (5,33,61); `row_end` on col 27; FILL takes 85 cycles.
- Test 3: continue the stride=1 frame → after REFILL, col 0 gives (28,56,84); exactly 26 `row_end` pulses, then a single `done` pulse.
- Test 4: stride=2 frame → second triplet col 0 gives (56,84,112); REFILL issues 56 reads; 13 `row_end` pulses before `done`.
- Test 5: toggle `shift_buffer` during REFILL and assert `start` during SERVE → `col` and outputs unchanged; frame result identical to Test 2.
- Test 6: with `LINE_FEEDER_ZERO_PAD_EN`, first shift gives (0,0,0), second gives (0,28,56), 30th gives (0,0,0) with `row_end`.
